result_record_fifo: RTL and testbench

- Sits directly downstream of the QPD demodulator and the OPD lock-in.
- Captures each position result (x1, i1, x2, i2) and each OPD result (x, y) as one tagged, sequence-numbered record, then buffers records in a synchronous FIFO.
- The processor-side register interface drains the FIFO with a valid/ready handshake, so no sample is lost or torn between register reads.
- Reports FIFO fill level and a saturating drop count.

---
 rtl/result_pkg.sv | 24 ++
 rtl/result_record_fifo_sync_fifo.sv | 55 +++++
 rtl/result_record_fifo.sv | 155 +++++++++++++++
 tb/tb_result_record_fifo.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared record layout and constants for the result record FIFO.
// record_t is the default-width record shape; the top rebuilds it for its own NUM_BITS.
package result_pkg;

  localparam int WORD_BITS       = 24;
  localparam int SEQ_BITS        = 32;
  localparam int DROP_COUNT_BITS = 16;

  localparam logic KIND_POS = 1'b0;
  localparam logic KIND_OPD = 1'b1;

  typedef struct packed {
    logic                      kind;
    logic [SEQ_BITS-1:0]       seq;
    logic [3:0][WORD_BITS-1:0] w;
  } record_t;

  localparam int RECORD_BITS = $bits(record_t);

  function automatic int record_bits(input int num_bits);
    return 1 + SEQ_BITS + 4 * num_bits;
  endfunction

endpackage

// File: rtl/result_record_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// The head word is read combinationally from the registered read pointer and forced to 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop while empty is ignored; a pop while full frees the slot a same-cycle push uses.
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/result_record_fifo.sv
// Tags position and OPD results as sequence-numbered records and buffers them for the register interface.
// Read side: a record transfers on a cycle where rd_valid_o && rd_ready_i; rd_* hold steady until then.
module result_record_fifo
  import result_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int NUM_BITS = 24
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        pos_tick_i,
  input  logic signed [NUM_BITS-1:0]  x1_i,
  input  logic signed [NUM_BITS-1:0]  i1_i,
  input  logic signed [NUM_BITS-1:0]  x2_i,
  input  logic signed [NUM_BITS-1:0]  i2_i,
  input  logic                        opd_tick_i,
  input  logic signed [NUM_BITS-1:0]  x_opd_i,
  input  logic signed [NUM_BITS-1:0]  y_opd_i,
  input  logic                        rd_ready_i,
  output logic                        rd_valid_o,
  output logic                        rd_kind_o,
  output logic [SEQ_BITS-1:0]         rd_seq_o,
  output logic signed [NUM_BITS-1:0]  rd_w0_o,
  output logic signed [NUM_BITS-1:0]  rd_w1_o,
  output logic signed [NUM_BITS-1:0]  rd_w2_o,
  output logic signed [NUM_BITS-1:0]  rd_w3_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic [DROP_COUNT_BITS-1:0]  drop_count_o
);

  typedef struct packed {
    logic                     kind;
    logic [SEQ_BITS-1:0]      seq;
    logic [3:0][NUM_BITS-1:0] w;
  } rec_t;

  localparam int REC_BITS = record_bits(NUM_BITS);
  localparam logic [SEQ_BITS-1:0] SEQ_ONE = 1;

  logic [SEQ_BITS-1:0]        r_seq_pos;
  logic [SEQ_BITS-1:0]        r_seq_opd;
  logic                       r_pend_valid;
  rec_t                       r_pend_rec;
  logic [DROP_COUNT_BITS-1:0] r_drop_count;

  rec_t                       w_pos_rec;
  rec_t                       w_opd_rec;
  rec_t                       w_wr_rec;
  rec_t                       w_pend_rec_nxt;
  rec_t                       w_head;
  logic [REC_BITS-1:0]        w_head_bits;
  logic                       w_push;
  logic                       w_pend_valid_nxt;
  logic                       w_pend_drop;
  logic                       w_full_drop;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [1:0]                 w_drop_inc;
  logic [DROP_COUNT_BITS:0]   w_drop_sum;

  always_comb begin
    w_pos_rec      = '0;
    w_pos_rec.kind = KIND_POS;
    w_pos_rec.seq  = r_seq_pos;
    w_pos_rec.w[0] = x1_i;
    w_pos_rec.w[1] = i1_i;
    w_pos_rec.w[2] = x2_i;
    w_pos_rec.w[3] = i2_i;
    w_opd_rec      = '0;
    w_opd_rec.kind = KIND_OPD;
    w_opd_rec.seq  = r_seq_opd;
    w_opd_rec.w[0] = x_opd_i;
    w_opd_rec.w[1] = y_opd_i;
  end

  // One FIFO write per cycle: a held record always goes first, position outranks OPD for the
  // write slot and the pending slot, and an OPD record that finds both taken is dropped.
  always_comb begin
    w_push           = 1'b0;
    w_wr_rec         = '0;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_rec_nxt   = r_pend_rec;
    w_pend_drop      = 1'b0;
    if (r_pend_valid) begin
      w_push           = 1'b1;
      w_wr_rec         = r_pend_rec;
      w_pend_valid_nxt = 1'b0;
      if (pos_tick_i) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_rec_nxt   = w_pos_rec;
        w_pend_drop      = opd_tick_i;
      end else if (opd_tick_i) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_rec_nxt   = w_opd_rec;
      end
    end else if (pos_tick_i) begin
      w_push   = 1'b1;
      w_wr_rec = w_pos_rec;
      if (opd_tick_i) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_rec_nxt   = w_opd_rec;
      end
    end else if (opd_tick_i) begin
      w_push   = 1'b1;
      w_wr_rec = w_opd_rec;
    end
  end

  // When full the head is valid, so rd_ready_i alone decides whether a slot frees up.
  assign w_full_drop = w_push && w_fifo_full && !rd_ready_i;
  assign w_drop_inc  = {1'b0, w_full_drop} + {1'b0, w_pend_drop};
  assign w_drop_sum  = {1'b0, r_drop_count} + {{(DROP_COUNT_BITS-1){1'b0}}, w_drop_inc};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_seq_pos    <= '0;
      r_seq_opd    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_rec   <= '0;
      r_drop_count <= '0;
    end else begin
      if (pos_tick_i) r_seq_pos <= r_seq_pos + SEQ_ONE;
      if (opd_tick_i) r_seq_opd <= r_seq_opd + SEQ_ONE;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_rec   <= w_pend_rec_nxt;
      r_drop_count <= w_drop_sum[DROP_COUNT_BITS] ? '1 : w_drop_sum[DROP_COUNT_BITS-1:0];
    end
  end

  sync_fifo #(
    .WIDTH (REC_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_push  (w_push),
    .i_data  (w_wr_rec),
    .i_pop   (rd_ready_i),
    .o_data  (w_head_bits),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (level_o)
  );

  assign w_head       = rec_t'(w_head_bits);
  assign rd_valid_o   = !w_fifo_empty;
  assign rd_kind_o    = w_head.kind;
  assign rd_seq_o     = w_head.seq;
  assign rd_w0_o      = w_head.w[0];
  assign rd_w1_o      = w_head.w[1];
  assign rd_w2_o      = w_head.w[2];
  assign rd_w3_o      = w_head.w[3];
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_result_record_fifo.sv
// Directed bench for result_record_fifo: inputs change on the falling edge, outputs are read there too.
module tb_result_record_fifo;

  localparam int DEPTH = 64;
  localparam int NB    = 24;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int RW    = 1 + 32 + 4 * NB;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b0;
  logic                 pos_tick = 1'b0;
  logic                 opd_tick = 1'b0;
  logic                 rd_ready = 1'b0;
  logic signed [NB-1:0] x1 = '0, i1 = '0, x2 = '0, i2 = '0;
  logic signed [NB-1:0] x_opd = '0, y_opd = '0;

  logic                 rd_valid;
  logic                 rd_kind;
  logic [31:0]          rd_seq;
  logic signed [NB-1:0] rd_w0, rd_w1, rd_w2, rd_w3;
  logic [LW-1:0]        level;
  logic [15:0]          drop_count;
  logic [RW-1:0]        head;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [RW-1:0] exp_q[$];
  logic [31:0]   m_seq_pos;
  logic [31:0]   m_seq_opd;

  assign head = {rd_kind, rd_seq, rd_w0, rd_w1, rd_w2, rd_w3};

  // clock / reset
  always #5 clk = ~clk;

  result_record_fifo #(.DEPTH(DEPTH), .NUM_BITS(NB)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pos_tick_i   (pos_tick),
    .x1_i         (x1),
    .i1_i         (i1),
    .x2_i         (x2),
    .i2_i         (i2),
    .opd_tick_i   (opd_tick),
    .x_opd_i      (x_opd),
    .y_opd_i      (y_opd),
    .rd_ready_i   (rd_ready),
    .rd_valid_o   (rd_valid),
    .rd_kind_o    (rd_kind),
    .rd_seq_o     (rd_seq),
    .rd_w0_o      (rd_w0),
    .rd_w1_o      (rd_w1),
    .rd_w2_o      (rd_w2),
    .rd_w3_o      (rd_w3),
    .level_o      (level),
    .drop_count_o (drop_count)
  );

  function automatic logic [RW-1:0] mk(input logic kind, input logic [31:0] seq,
                                       input logic [NB-1:0] a, input logic [NB-1:0] b,
                                       input logic [NB-1:0] c, input logic [NB-1:0] d);
    return {kind, seq, a, b, c, d};
  endfunction

  // driver tasks: each starts and ends on a falling edge
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; pos_tick = 1'b0; opd_tick = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_pos(input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic [NB-1:0] c, input logic [NB-1:0] d);
    pos_tick = 1'b1; x1 = a; i1 = b; x2 = c; i2 = d;
    @(negedge clk);
    pos_tick = 1'b0;
  endtask

  task automatic drive_opd(input logic [NB-1:0] a, input logic [NB-1:0] b);
    opd_tick = 1'b1; x_opd = a; y_opd = b;
    @(negedge clk);
    opd_tick = 1'b0;
  endtask

  task automatic drive_both(input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input logic [NB-1:0] c, input logic [NB-1:0] d,
                            input logic [NB-1:0] e, input logic [NB-1:0] f);
    pos_tick = 1'b1; x1 = a; i1 = b; x2 = c; i2 = d;
    opd_tick = 1'b1; x_opd = e; y_opd = f;
    @(negedge clk);
    pos_tick = 1'b0; opd_tick = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({rd_valid, level, drop_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: valid=%0b level=%0d drop=%0d required 0/0/0", rd_valid, level, drop_count);
    end
    tests_run++;
    if (head !== '0) begin
      tests_failed++;
      $display("FAIL reset_head: got %h required 0", head);
    end
  endtask

  task automatic test_single_pos();
    apply_reset();
    drive_pos(24'sd100, -24'sd5, 24'sd7, 24'h800000);
    tests_run++;
    if (rd_valid !== 1'b1 || level !== 7'd1) begin
      tests_failed++;
      $display("FAIL single_visible: valid=%0b level=%0d required 1/1", rd_valid, level);
    end
    tests_run++;
    if (head !== mk(1'b0, 32'd0, 24'sd100, -24'sd5, 24'sd7, 24'h800000)) begin
      tests_failed++;
      $display("FAIL single_head: got %h required %h", head, mk(1'b0, 32'd0, 24'sd100, -24'sd5, 24'sd7, 24'h800000));
    end
    pop_one();
    tests_run++;
    if (rd_valid !== 1'b0 || level !== 7'd0 || head !== '0) begin
      tests_failed++;
      $display("FAIL single_pop: valid=%0b level=%0d head=%h required 0/0/0", rd_valid, level, head);
    end
  endtask

  task automatic test_empty_pop_push();
    apply_reset();
    rd_ready = 1'b1;
    drive_pos(24'd1, 24'd2, 24'd3, 24'd4);
    tests_run++;
    if (level !== 7'd1 || head !== mk(1'b0, 32'd0, 24'd1, 24'd2, 24'd3, 24'd4)) begin
      tests_failed++;
      $display("FAIL empty_pop_push: level=%0d head=%h required 1 and seq 0 record", level, head);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    tests_run++;
    if (level !== 7'd0) begin
      tests_failed++;
      $display("FAIL empty_pop_push_drain: level=%0d required 0", level);
    end
  endtask

  task automatic test_pos_opd_collision();
    apply_reset();
    drive_both(24'd1, 24'd2, 24'd3, 24'd4, 24'sd3, -24'sd3);
    tests_run++;
    if (level !== 7'd1 || head !== mk(1'b0, 32'd0, 24'd1, 24'd2, 24'd3, 24'd4)) begin
      tests_failed++;
      $display("FAIL collide_first: level=%0d head=%h required 1 and pos seq 0", level, head);
    end
    @(negedge clk);
    tests_run++;
    if (level !== 7'd2) begin
      tests_failed++;
      $display("FAIL collide_level: level=%0d required 2", level);
    end
    pop_one();
    tests_run++;
    if (head !== mk(1'b1, 32'd0, 24'sd3, -24'sd3, 24'd0, 24'd0)) begin
      tests_failed++;
      $display("FAIL collide_opd: got %h required %h", head, mk(1'b1, 32'd0, 24'sd3, -24'sd3, 24'd0, 24'd0));
    end
    pop_one();
  endtask

  task automatic test_pending_overwrite();
    apply_reset();
    drive_both(24'd10, 24'd11, 24'd12, 24'd13, 24'd20, 24'd21);
    drive_both(24'd30, 24'd31, 24'd32, 24'd33, 24'd40, 24'd41);
    @(negedge clk);
    tests_run++;
    if (level !== 7'd3 || drop_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL overwrite_status: level=%0d drop=%0d required 3/1", level, drop_count);
    end
    tests_run++;
    if (head !== mk(1'b0, 32'd0, 24'd10, 24'd11, 24'd12, 24'd13)) begin
      tests_failed++;
      $display("FAIL overwrite_rec0: got %h", head);
    end
    pop_one();
    tests_run++;
    if (head !== mk(1'b1, 32'd0, 24'd20, 24'd21, 24'd0, 24'd0)) begin
      tests_failed++;
      $display("FAIL overwrite_rec1: got %h", head);
    end
    pop_one();
    tests_run++;
    if (head !== mk(1'b0, 32'd1, 24'd30, 24'd31, 24'd32, 24'd33)) begin
      tests_failed++;
      $display("FAIL overwrite_rec2: got %h", head);
    end
    pop_one();
    drive_opd(24'd50, 24'd51);
    tests_run++;
    if (head !== mk(1'b1, 32'd2, 24'd50, 24'd51, 24'd0, 24'd0)) begin
      tests_failed++;
      $display("FAIL overwrite_opd_seq: got seq %0d required 2", rd_seq);
    end
    pop_one();
  endtask

  task automatic test_full_and_pop_push();
    apply_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive_pos(NB'(i), NB'(i + 1), NB'(i + 2), NB'(i + 3));
    end
    tests_run++;
    if (level !== 7'd64 || drop_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL full_status: level=%0d drop=%0d required 64/3", level, drop_count);
    end
    tests_run++;
    if (head !== mk(1'b0, 32'd0, 24'd0, 24'd1, 24'd2, 24'd3)) begin
      tests_failed++;
      $display("FAIL full_head: got %h", head);
    end
    // pop and push in the same cycle while full
    rd_ready = 1'b1;
    drive_pos(24'd500, 24'd501, 24'd502, 24'd503);
    rd_ready = 1'b0;
    tests_run++;
    if (level !== 7'd64 || drop_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL full_pop_push: level=%0d drop=%0d required 64/3", level, drop_count);
    end
    for (int k = 1; k < DEPTH; k++) begin
      tests_run++;
      if (head !== mk(1'b0, 32'(k), NB'(k), NB'(k + 1), NB'(k + 2), NB'(k + 3))) begin
        tests_failed++;
        $display("FAIL full_drain_%0d: got seq %0d required %0d", k, rd_seq, k);
      end
      pop_one();
    end
    tests_run++;
    if (head !== mk(1'b0, 32'd67, 24'd500, 24'd501, 24'd502, 24'd503)) begin
      tests_failed++;
      $display("FAIL full_last: got seq %0d required 67", rd_seq);
    end
    pop_one();
    tests_run++;
    if (level !== 7'd0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_empty: level=%0d valid=%0b required 0/0", level, rd_valid);
    end
  endtask

  task automatic test_hold_and_reset();
    apply_reset();
    drive_pos(24'd11, 24'd12, 24'd13, 24'd14);
    drive_pos(24'd21, 24'd22, 24'd23, 24'd24);
    for (int k = 0; k < 4; k++) begin
      x1 = NB'($urandom); i1 = NB'($urandom); x2 = NB'($urandom); i2 = NB'($urandom);
      x_opd = NB'($urandom); y_opd = NB'($urandom);
      @(negedge clk);
      tests_run++;
      if (head !== mk(1'b0, 32'd0, 24'd11, 24'd12, 24'd13, 24'd14) || rd_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_%0d: got %h", k, head);
      end
    end
    drive_both(24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1);
    drive_both(24'd2, 24'd2, 24'd2, 24'd2, 24'd2, 24'd2);
    tests_run++;
    if (drop_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL hold_drop: drop=%0d required 1", drop_count);
    end
    // reset lands while a pending record and a new tick are in flight
    reset = 1'b1; pos_tick = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; pos_tick = 1'b0; rd_ready = 1'b0;
    tests_run++;
    if (level !== 7'd0 || rd_valid !== 1'b0 || drop_count !== 16'd0 || head !== '0) begin
      tests_failed++;
      $display("FAIL midreset: level=%0d valid=%0b drop=%0d required 0/0/0", level, rd_valid, drop_count);
    end
    drive_pos(24'd9, 24'd8, 24'd7, 24'd6);
    tests_run++;
    if (level !== 7'd1 || head !== mk(1'b0, 32'd0, 24'd9, 24'd8, 24'd7, 24'd6)) begin
      tests_failed++;
      $display("FAIL midreset_seq: level=%0d seq=%0d required 1/0", level, rd_seq);
    end
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    force dut.r_seq_pos = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_seq_pos;
    drive_pos(24'd1, 24'd2, 24'd3, 24'd4);
    drive_pos(24'd5, 24'd6, 24'd7, 24'd8);
    tests_run++;
    if (head !== mk(1'b0, 32'hFFFF_FFFF, 24'd1, 24'd2, 24'd3, 24'd4)) begin
      tests_failed++;
      $display("FAIL wrap_max: got seq %h required ffffffff", rd_seq);
    end
    pop_one();
    tests_run++;
    if (head !== mk(1'b0, 32'd0, 24'd5, 24'd6, 24'd7, 24'd8)) begin
      tests_failed++;
      $display("FAIL wrap_zero: got seq %h required 0", rd_seq);
    end
    pop_one();
  endtask

  task automatic test_random_traffic();
    int            issued;
    logic [RW-1:0] e;
    logic [NB-1:0] a, b, c, d;
    issued = 0;
    apply_reset();
    m_seq_pos = '0;
    m_seq_opd = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      rd_ready = 1'($urandom_range(0, 1));
      tests_run++;
      if (rd_valid !== (exp_q.size() != 0) || level !== LW'(exp_q.size())) begin
        tests_failed++;
        $display("FAIL rand_level_%0d: valid=%0b level=%0d required level %0d", cyc, rd_valid, level, exp_q.size());
      end
      if (rd_valid && rd_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (head !== e) begin
          tests_failed++;
          $display("FAIL rand_head_%0d: got %h required %h", cyc, head, e);
        end
      end
      pos_tick = 1'b0;
      opd_tick = 1'b0;
      if (issued < 40 && $urandom_range(0, 2) == 0) begin
        issued++;
        a = NB'($urandom); b = NB'($urandom); c = NB'($urandom); d = NB'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          pos_tick = 1'b1; x1 = a; i1 = b; x2 = c; i2 = d;
          exp_q.push_back(mk(1'b0, m_seq_pos, a, b, c, d));
          m_seq_pos++;
        end else begin
          opd_tick = 1'b1; x_opd = a; y_opd = b;
          exp_q.push_back(mk(1'b1, m_seq_opd, a, b, '0, '0));
          m_seq_opd++;
        end
      end
      @(negedge clk);
    end
    pos_tick = 1'b0;
    opd_tick = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (rd_valid !== 1'b1 || head !== e) begin
        tests_failed++;
        $display("FAIL rand_drain_%0d: valid=%0b got %h required %h", k, rd_valid, head, e);
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    tests_run++;
    if (level !== 7'd0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_end: level=%0d valid=%0b required 0/0", level, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_pos();
    test_empty_pop_push();
    test_pos_opd_collision();
    test_pending_overwrite();
    test_full_and_pop_push();
    test_hold_and_reset();
    test_seq_wrap();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
